// File: rtl/fetch_unit.sv
// Instruction-fetch / PC-sequencing stage. Owns the program counter, fetches
// one word at a time over a req/resp handshake, holds it for decode until the
// execute side acks, then redirects or advances the PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  pc_control,
  input  logic [25:0] jump_addr,
  input  logic [15:0] branch_imm,
  input  logic [31:0] jr_target,
  input  logic        instr_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        pc_nxt;
  logic               misalign_nxt;
  logic               ack_fire;
  logic signed [31:0] branch_off;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign ack_fire  = (state == HOLD) && instr_ack;

  // Next-state and handshake outputs; only one instruction is ever in flight.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) state_nxt = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ack) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Redirect decode: codes 1xx fall into the sequential default.
  always_comb begin
    branch_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    pc_nxt       = pc_plus4;
    misalign_nxt = 1'b0;
    case (pc_control)
      3'b001: pc_nxt = {pc_plus4[31:28], jump_addr, 2'b00};
      3'b010: begin
        pc_nxt       = {jr_target[31:2], 2'b00};
        misalign_nxt = (jr_target[1:0] != 2'b00);
      end
      3'b011: pc_nxt = pc_plus4 + branch_off;
      default: pc_nxt = pc_plus4;
    endcase
  end

  // FSM state register; reset drops any response still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // PC, held instruction, retire counter and the one-cycle misalign pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_count <= 32'd0;
      misalign    <= 1'b0;
    end else begin
      misalign <= ack_fire && misalign_nxt;
      if ((state == WAIT) && imem_rvalid) instr <= imem_rdata;
      if (ack_fire) begin
        pc          <= pc_nxt;
        instr_count <= instr_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: the bench plays instruction memory and
// the execute side, and tracks PC / retire count with a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  pc_control;
  logic [25:0] jump_addr;
  logic [15:0] branch_imm;
  logic [31:0] jr_target;
  logic        instr_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_count;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .pc_control(pc_control), .jump_addr(jump_addr), .branch_imm(branch_imm),
    .jr_target(jr_target), .instr_ack(instr_ack),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .misalign(misalign), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC from the redirect rules, using plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [2:0] ctrl,
                                             input logic [25:0] ja, input logic [15:0] bi,
                                             input logic [31:0] jr);
    logic signed [31:0] off;
    logic [31:0] seq;
    seq = cur + 32'd4;
    off = $signed(bi);
    if (ctrl == 3'd1)      return (seq & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
    else if (ctrl == 3'd2) return jr & ~32'd3;
    else if (ctrl == 3'd3) return seq + 32'(off * 4);
    else                   return seq;
  endfunction

  // One full instruction: rw ready-wait cycles, vw rvalid-wait cycles, aw ack-wait cycles.
  task automatic run_instr(input int rw, input int vw, input int aw, input logic [2:0] ctrl,
                           input logic [25:0] ja, input logic [15:0] bi, input logic [31:0] jr);
    logic [31:0] data;
    logic [31:0] exp_pc;
    logic        exp_mis;
    data = $urandom;
    for (int i = 0; i <= rw; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL fetch_phase req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                 imem_req, imem_addr, instr_valid, m_pc);
      end
      imem_ready  = (i == rw);
      imem_rvalid = 1'($urandom);
      imem_rdata  = $urandom;
      instr_ack   = 1'($urandom);
      pc_control  = 3'($urandom);
      jr_target   = $urandom;
      step();
      if (i == 0) begin
        total++;
        if (misalign !== 1'b0) begin
          bad++;
          $display("FAIL misalign_not_sticky misalign=%b, required 0", misalign);
        end
      end
    end
    imem_ready = 1'b0;
    for (int i = 0; i <= vw; i++) begin
      total++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL wait_phase req=%b valid=%b, required req=0 valid=0", imem_req, instr_valid);
      end
      imem_rvalid = (i == vw);
      imem_rdata  = (i == vw) ? data : $urandom;
      imem_ready  = 1'($urandom);
      instr_ack   = 1'($urandom);
      step();
    end
    imem_rvalid = 1'b0;
    imem_ready  = 1'b0;
    for (int i = 0; i <= aw; i++) begin
      total++;
      if (instr_valid !== 1'b1 || instr !== data || pc !== m_pc || pc_plus4 !== m_pc + 32'd4
          || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL hold_phase valid=%b instr=%h pc=%h pc4=%h req=%b, required 1 %h %h %h 0",
                 instr_valid, instr, pc, pc_plus4, imem_req, data, m_pc, m_pc + 32'd4);
      end
      instr_ack   = (i == aw);
      pc_control  = (i == aw) ? ctrl : 3'($urandom);
      jump_addr   = (i == aw) ? ja   : 26'($urandom);
      branch_imm  = (i == aw) ? bi   : 16'($urandom);
      jr_target   = (i == aw) ? jr   : $urandom;
      imem_rvalid = 1'($urandom);
      imem_rdata  = $urandom;
      step();
    end
    instr_ack   = 1'b0;
    imem_rvalid = 1'b0;
    pc_control  = 3'($urandom);
    jump_addr   = 26'($urandom);
    branch_imm  = 16'($urandom);
    jr_target   = $urandom;
    exp_pc  = model_next(m_pc, ctrl, ja, bi, jr);
    exp_mis = (ctrl == 3'd2) && (jr % 4 != 0);
    m_pc    = exp_pc;
    m_count = m_count + 32'd1;
    total++;
    if (pc !== m_pc || imem_addr !== m_pc || instr_count !== m_count || misalign !== exp_mis
        || instr_valid !== 1'b0 || imem_req !== 1'b1 || instr !== data) begin
      bad++;
      $display("FAIL after_ack pc=%h addr=%h count=%0d mis=%b valid=%b req=%b instr=%h, required %h %h %0d %b 0 1 %h",
               pc, imem_addr, instr_count, misalign, instr_valid, imem_req, instr,
               m_pc, m_pc, m_count, exp_mis, data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pc_control = 3'd0; jump_addr = 26'd0; branch_imm = 16'd0; jr_target = 32'd0;
    instr_ack = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    #1;
    total++;
    if (pc !== RESET_PC || instr !== 32'd0 || instr_valid !== 1'b0 || misalign !== 1'b0
        || instr_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_values pc=%h instr=%h valid=%b mis=%b count=%0d, required %h 0 0 0 0",
               pc, instr, instr_valid, misalign, instr_count, RESET_PC);
    end
    step();
    step();
    rst = 1'b0;
    m_pc = RESET_PC;
    m_count = 32'd0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL reset_first_req req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) run_instr(0, 0, 0, 3'd0, 26'd0, 16'd0, 32'd0);
    total++;
    if (imem_addr !== 32'h0000_000C || instr_count !== 32'd3) begin
      bad++;
      $display("FAIL seq_three addr=%h count=%0d, required 0000000c 3", imem_addr, instr_count);
    end
  endtask

  task automatic test_jump();
    run_instr(0, 0, 0, 3'd2, 26'd0, 16'd0, 32'h0040_0010);
    run_instr(0, 0, 0, 3'd1, 26'h0000100, 16'd0, 32'd0);
    total++;
    if (imem_addr !== 32'h0000_0400) begin
      bad++;
      $display("FAIL jump_target addr=%h, required 00000400", imem_addr);
    end
  endtask

  task automatic test_branch();
    run_instr(0, 0, 0, 3'd2, 26'd0, 16'd0, 32'h0000_0100);
    run_instr(0, 0, 0, 3'd3, 26'd0, 16'hFFFC, 32'd0);
    total++;
    if (pc !== 32'h0000_00F4) begin
      bad++;
      $display("FAIL branch_back pc=%h, required 000000f4", pc);
    end
    run_instr(0, 0, 0, 3'd2, 26'd0, 16'd0, 32'h0000_0100);
    run_instr(0, 0, 0, 3'd3, 26'd0, 16'h0003, 32'd0);
    total++;
    if (pc !== 32'h0000_0110) begin
      bad++;
      $display("FAIL branch_fwd pc=%h, required 00000110", pc);
    end
  endtask

  task automatic test_jr_misalign();
    run_instr(0, 0, 0, 3'd2, 26'd0, 16'd0, 32'h0000_2006);
    total++;
    if (pc !== 32'h0000_2004 || misalign !== 1'b1) begin
      bad++;
      $display("FAIL jr_misaligned pc=%h mis=%b, required 00002004 1", pc, misalign);
    end
    run_instr(0, 0, 0, 3'd2, 26'd0, 16'd0, 32'h0000_2004);
    total++;
    if (pc !== 32'h0000_2004 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL jr_aligned pc=%h mis=%b, required 00002004 0", pc, misalign);
    end
  endtask

  task automatic test_wait_states();
    run_instr(2, 3, 1, 3'd0, 26'd0, 16'd0, 32'd0);
  endtask

  task automatic test_reset_in_wait();
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL rstwait_pre req=%b, required 1", imem_req);
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    total++;
    if (pc !== RESET_PC || instr !== 32'd0 || instr_valid !== 1'b0 || misalign !== 1'b0
        || instr_count !== 32'd0) begin
      bad++;
      $display("FAIL rstwait_async pc=%h instr=%h valid=%b mis=%b count=%0d, required %h 0 0 0 0",
               pc, instr, instr_valid, misalign, instr_count, RESET_PC);
    end
    step();
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL rstwait_late_rvalid valid=%b req=%b addr=%h, required 0 1 %h",
               instr_valid, imem_req, imem_addr, RESET_PC);
    end
    m_pc = RESET_PC;
    m_count = 32'd0;
    run_instr(0, 1, 0, 3'd0, 26'd0, 16'd0, 32'd0);
  endtask

  task automatic test_wrap();
    run_instr(0, 0, 0, 3'd2, 26'd0, 16'd0, 32'hFFFF_FFFC);
    run_instr(0, 0, 0, 3'd0, 26'd0, 16'd0, 32'd0);
    total++;
    if (imem_addr !== 32'h0000_0000) begin
      bad++;
      $display("FAIL wrap_seq addr=%h, required 00000000", imem_addr);
    end
    run_instr(0, 0, 0, 3'b110, 26'h3FF_FFFF, 16'h8000, 32'h1234_5678);
    total++;
    if (pc !== 32'h0000_0004) begin
      bad++;
      $display("FAIL ctrl_110_seq pc=%h, required 00000004", pc);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                3'($urandom), 26'($urandom), 16'($urandom), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) run_instr(0, 0, 0, 3'd0, 26'd0, 16'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_jr_misalign();
    test_wait_states();
    test_reset_in_wait();
    test_wrap();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
